serializer_16: RTL and testbench

- Parallel-to-serial converter. Feeds a single-bit stream into the programmable delay line (delay_15 data_i).
- Captures one DATA_W-bit word plus a bit count, then shifts it out MSB-first at one bit per clock.
- Drives a valid qualifier so downstream stages and benches can tell real stream bits from idle.

---
 rtl/serializer_16_if.sv | 32 +++
 rtl/serializer_16.sv | 93 +++++++++
 tb/tb_serializer_16.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serializer_16_if.sv
// Word-in / bit-out bundle between a word source and serializer_16.
// The slave side is the serializer; the master side feeds it words and watches the stream.
interface serializer_16_if #(
    parameter int DATA_W = 16
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] data_i;
    logic [CNT_W-1:0]  data_mod_i;
    logic              data_val_i;
    logic              ser_data_o;
    logic              ser_data_val_o;
    logic              busy_o;

    modport slave (
        input  data_i,
        input  data_mod_i,
        input  data_val_i,
        output ser_data_o,
        output ser_data_val_o,
        output busy_o
    );

    modport master (
        output data_i,
        output data_mod_i,
        output data_val_i,
        input  ser_data_o,
        input  ser_data_val_o,
        input  busy_o
    );
endinterface

// File: rtl/serializer_16.sv
// Parallel-to-serial converter: captures a word and bit count, shifts it out MSB-first,
// with one armed cycle between acceptance and the first bit.
//
// state | meaning
// IDLE  | no bits on the wire; load_q marks a captured word waiting to start
// SHIFT | one valid bit per cycle, counter counts down to the last bit
module serializer_16 #(
    parameter  int DATA_W = 16,
    localparam int CNT_W  = $clog2(DATA_W)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    serializer_16_if.slave  bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W:0] N_MAX = DATA_W[CNT_W:0];
    localparam logic [CNT_W:0] N_MIN = 3;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_q, load_d;

    logic [CNT_W:0]    n_eff;
    logic [CNT_W:0]    n_m1;
    logic [CNT_W-1:0]  cnt_load;
    logic              last_bit;
    logic              accept;

    // Length is held one bit wider so a full-width word loads DATA_W-1 without overflow.
    assign n_eff    = (bus.data_mod_i == '0) ? N_MAX : {1'b0, bus.data_mod_i};
    assign n_m1     = n_eff - 1'b1;
    assign cnt_load = n_m1[CNT_W-1:0];
    assign last_bit = (state_q == SHIFT) && (cnt_q == '0);

    // The edge that ends the last bit may take the next word, giving exactly one idle gap.
    assign accept = bus.data_val_i && (n_eff >= N_MIN) &&
                    (((state_q == IDLE) && !load_q) || last_bit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_q) begin
                    state_d = SHIFT;
                end else if (accept) begin
                    shift_d = bus.data_i;
                    cnt_d   = cnt_load;
                    load_d  = 1'b1;
                end
            end
            SHIFT: begin
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (accept) begin
                        shift_d = bus.data_i;
                        cnt_d   = cnt_load;
                        load_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ser_data_val_o = (state_q == SHIFT);
    assign bus.busy_o         = (state_q == SHIFT);
    assign bus.ser_data_o     = (state_q == SHIFT) && shift_q[DATA_W-1];
endmodule

// File: tb/tb_serializer_16.sv
// Bench for serializer_16: table of single words, hand-written back-to-back and
// mid-word reset sequences, and random traffic against a per-cycle expected stream.
module tb_serializer_16;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serializer_16_if #(.DATA_W(W)) bus();

    serializer_16 #(.DATA_W(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
        int          len;
        logic [15:0] bits;
    } vec_t;

    vec_t tbl [7];

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   avail  = 0;
    logic exp_v [0:4095];
    logic exp_d [0:4095];

    logic [15:0] got_bits;
    int          got_len;
    logic [9:0]  vpat, dpat;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, edge_n, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Reference: a word accepted at edge e is shown after edges e+1..e+N;
    // the next word can be taken from edge e+N+1 on.
    task automatic model_edge();
        int n;
        if (!rst && bus.data_val_i) begin
            n = (bus.data_mod_i == 0) ? W : int'(bus.data_mod_i);
            if (n >= 3 && edge_n >= avail) begin
                for (int j = 0; j < n; j++) begin
                    exp_v[edge_n + 1 + j] = 1'b1;
                    exp_d[edge_n + 1 + j] = bus.data_i[W - 1 - j];
                end
                avail = edge_n + n + 1;
            end
        end
    endtask

    task automatic clear_model();
        for (int i = edge_n + 1; i < 4096; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = 1'b0;
        end
        avail = 0;
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic [3:0] m);
        bus.data_val_i = v;
        bus.data_i     = d;
        bus.data_mod_i = m;
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        check_bit("valid", bus.ser_data_val_o, exp_v[edge_n]);
        check_bit("data",  bus.ser_data_o,     exp_d[edge_n]);
        check_bit("busy",  bus.busy_o,         exp_v[edge_n]);
        if (bus.ser_data_val_o) begin
            if (got_len < 16) got_bits[15 - got_len] = bus.ser_data_o;
            got_len++;
        end
    endtask

    task automatic run_word(input logic [15:0] d, input logic [3:0] m, input string tag,
                            input int len, input logic [15:0] bits);
        got_bits = '0;
        got_len  = 0;
        step(1'b1, d, m);
        repeat (19) step(1'b0, 16'($urandom), 4'($urandom));
        check_int({tag, "_len"},  got_len,       len);
        check_int({tag, "_bits"}, int'(got_bits), int'(bits));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = 1'b0;
        end
        tbl[0] = '{16'hA5C3, 4'd0,  16, 16'hA5C3};
        tbl[1] = '{16'hF000, 4'd5,  5,  16'hF000};
        tbl[2] = '{16'h1234, 4'd1,  0,  16'h0000};
        tbl[3] = '{16'hFFFF, 4'd2,  0,  16'h0000};
        tbl[4] = '{16'hE000, 4'd3,  3,  16'hE000};
        tbl[5] = '{16'h8001, 4'd0,  16, 16'h8001};
        tbl[6] = '{16'hB6D9, 4'd15, 15, 16'hB6D8};
        got_bits = '0;
        got_len  = 0;

        rst = 1'b1;
        repeat (3) step(1'b0, 16'h0000, 4'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_word(tbl[i].data, tbl[i].mod, $sformatf("tbl%0d", i), tbl[i].len, tbl[i].bits);
        end

        // Held strobe: 1111, one idle cycle, 0000; strobes during a word are dropped.
        step(1'b1, 16'hFFFF, 4'd4);
        vpat[9] = bus.ser_data_val_o;
        dpat[9] = bus.ser_data_o;
        for (int i = 1; i < 10; i++) begin
            step(1'b1, 16'h0000, 4'd4);
            vpat[9 - i] = bus.ser_data_val_o;
            dpat[9 - i] = bus.ser_data_o;
        end
        check_int("b2b_valid", int'(vpat), int'(10'b0111101111));
        check_int("b2b_data",  int'(dpat), int'(10'b0111100000));
        repeat (10) step(1'b0, 16'($urandom), 4'($urandom));

        // Reset while the 6th bit of a full word is on the wire.
        step(1'b1, 16'hC3A5, 4'd0);
        repeat (6) step(1'b0, 16'h0000, 4'd0);
        check_bit("pre_rst_valid", bus.ser_data_val_o, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("rst_valid", bus.ser_data_val_o, 1'b0);
        check_bit("rst_busy",  bus.busy_o,         1'b0);
        check_bit("rst_data",  bus.ser_data_o,     1'b0);
        clear_model();
        repeat (2) step(1'b1, 16'hFFFF, 4'd0);
        rst = 1'b0;
        run_word(16'h8001, 4'd0, "post_rst", 16, 16'h8001);

        repeat (400) step($urandom_range(0, 2) == 0, 16'($urandom), 4'($urandom));
        repeat (20) step(1'b0, 16'h0000, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
